// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing arbiter: FSM encoding and
// the bit positions of the per-requester {a_signed, b_signed} field.
package mult_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam int SM_W     = 2;
  localparam int SM_A_BIT = 1;
  localparam int SM_B_BIT = 0;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin priority search: first asserted request at or above ptr_i,
// wrapping at NREQ-1. Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  id_o
);

  int             idx;
  logic [IDW-1:0] idx_w;
  logic           found;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found   = 1'b0;
    idx     = 0;
    idx_w   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx   = (int'(ptr_i) + i) % NREQ;
      idx_w = IDW'(idx);
      if (!found && req_i[idx_w]) begin
        found          = 1'b1;
        grant_o[idx_w] = 1'b1;
        id_o           = idx_w;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one external multiplier among NREQ requesters: round-robin grant,
// single outstanding operation, timeout abort, result held until accepted.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [2*NREQ-1:0]       req_sign_mode,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic [SM_W-1:0]         mul_sign_mode,
  input  logic [2*WIDTH-1:0]      mul_product,
  input  logic                    mul_done,
  input  logic                    mul_busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d, id_q;
  logic [CW-1:0]     cnt_q;
  logic              mul_start_q, rsp_err_q;
  logic [WIDTH-1:0]  mul_a_q, mul_b_q;
  logic [SM_W-1:0]   mul_sm_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [2*WIDTH-1:0] rsp_product_q;

  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_id;
  logic              handshake;

  logic [WIDTH-1:0]  a_arr  [NREQ];
  logic [WIDTH-1:0]  b_arr  [NREQ];
  logic [SM_W-1:0]   sm_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g]  = req_b[g*WIDTH +: WIDTH];
    assign sm_arr[g] = {req_sign_mode[2*g+SM_A_BIT], req_sign_mode[2*g+SM_B_BIT]};
  end

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .id_o    (grant_id)
  );

  // Grant is re-evaluated every cycle so a withdrawn request never wins.
  assign req_ready = (rst_n && state_q == ST_IDLE && !mul_busy) ? grant : '0;
  assign handshake = |(req_valid & req_ready);
  assign rr_ptr_d  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= '0;
      id_q          <= '0;
      cnt_q         <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      mul_sm_q      <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      mul_start_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (handshake) begin
            mul_a_q     <= a_arr[grant_id];
            mul_b_q     <= b_arr[grant_id];
            mul_sm_q    <= sm_arr[grant_id];
            id_q        <= grant_id;
            rr_ptr_q    <= rr_ptr_d;
            mul_start_q <= 1'b1;
            state_q     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (mul_done) begin
            rsp_product_q <= mul_product;
            rsp_err_q     <= 1'b0;
            rsp_valid_q   <= NREQ'(1) << id_q;
            state_q       <= ST_RESP;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Abort: the multiplier never answered within TIMEOUT wait cycles.
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b1;
            rsp_valid_q   <= NREQ'(1) << id_q;
            state_q       <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[id_q]) begin
            rsp_valid_q <= '0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mul_start     = mul_start_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign mul_sign_mode = mul_sm_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_product   = rsp_product_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural latency-L multiplier.
module tb_mult_share_arbiter;

  localparam int NREQ = 4, WIDTH = 16, TIMEOUT = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NREQ-1:0]        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*WIDTH-1:0]  req_a, req_b;
  logic [2*NREQ-1:0]      req_sign_mode;
  logic [2*WIDTH-1:0]     rsp_product, mul_product;
  logic                   rsp_err, mul_start, mul_done, mul_busy;
  logic [WIDTH-1:0]       mul_a, mul_b;
  logic [1:0]             mul_sign_mode;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sign_mode(req_sign_mode),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_sign_mode(mul_sign_mode),
    .mul_product(mul_product), .mul_done(mul_done), .mul_busy(mul_busy)
  );

  // Behavioural multiplier: mul_done pulses lat cycles after the mul_start cycle.
  int              lat = 6;
  logic            model_en = 1'b1;
  logic            stray = 1'b0;
  logic            m_busy, m_done;
  logic [31:0]     m_prod, m_res;
  int              m_cnt;

  function automatic logic [31:0] calc(logic [15:0] a, logic [15:0] b, logic [1:0] sm);
    longint ax, bx, p;
    ax = sm[1] ? longint'($signed(a)) : longint'({48'b0, a});
    bx = sm[0] ? longint'($signed(b)) : longint'({48'b0, b});
    p  = ax * bx;
    return p[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= 0; m_prod <= '0; m_res <= '0;
    end else begin
      m_done <= 1'b0;
      if (mul_start) begin
        m_busy <= 1'b1;
        m_cnt  <= lat - 1;
        m_prod <= calc(mul_a, mul_b, mul_sign_mode);
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_done <= model_en;
          m_busy <= 1'b0;
          m_res  <= m_prod;
          m_cnt  <= 0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  assign mul_busy    = m_busy;
  assign mul_done    = m_done | stray;
  assign mul_product = stray ? 32'hDEADBEEF : m_res;

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"},   64'(req_ready),   64'd0);
    chk({tag, "_rsp_valid"},   64'(rsp_valid),   64'd0);
    chk({tag, "_rsp_product"}, 64'(rsp_product), 64'd0);
    chk({tag, "_rsp_err"},     64'(rsp_err),     64'd0);
    chk({tag, "_mul_start"},   64'(mul_start),   64'd0);
    chk({tag, "_mul_ab"},      64'({mul_a, mul_b}), 64'd0);
    chk({tag, "_mul_sm"},      64'(mul_sign_mode), 64'd0);
  endtask

  // One full transaction from requester id; hold = cycles rsp_ready stays low.
  task automatic do_txn(input int id, input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] sm, input logic [31:0] exp,
                        input logic exp_err, input int exp_lat, input int hold);
    logic [NREQ-1:0] oh;
    logic [31:0]     held;
    bit              got;
    int              n;
    oh = NREQ'(1) << id;
    req_a[id*WIDTH +: WIDTH] = a;
    req_b[id*WIDTH +: WIDTH] = b;
    req_sign_mode[2*id +: 2] = sm;
    req_valid = oh;
    #1;
    got = 0;
    for (int k = 0; k < 50; k++) begin
      if (req_ready != '0) begin got = 1; break; end
      tick();
    end
    chk("grant_seen", 64'(got), 64'd1);
    chk("grant_onehot", 64'(req_ready), 64'(oh));
    tick();
    req_valid = '0;
    chk("mul_start_T1", 64'(mul_start), 64'd1);
    chk("mul_operands", 64'({mul_a, mul_b, mul_sign_mode}), 64'({a, b, sm}));
    n = 0; got = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      n++;
      if (n == 1) chk("mul_start_pulse", 64'(mul_start), 64'd0);
      if (rsp_valid != '0) begin got = 1; break; end
    end
    chk("rsp_seen", 64'(got), 64'd1);
    chk("rsp_latency", 64'(n), 64'(exp_lat + 1));
    chk("rsp_valid_id", 64'(rsp_valid), 64'(oh));
    chk("rsp_product", 64'(rsp_product), 64'(exp));
    chk("rsp_err", 64'(rsp_err), 64'(exp_err));
    held = rsp_product;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = ~oh;
      req_valid = ~oh;
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'(oh));
      chk("hold_product", 64'(rsp_product), 64'(held));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    req_valid = '0;
    rsp_ready = oh;
    tick();
    rsp_ready = '0;
    chk("rsp_release", 64'(rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset");
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int          id;
    logic [15:0] a, b;
    logic [1:0]  sm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   rr_exp[5];

  initial begin
    vecs[0] = '{0, 16'hFFFD, 16'h0005, 2'b11, 32'hFFFFFFF1};
    vecs[1] = '{2, 16'hFFFF, 16'hFFFF, 2'b00, 32'hFFFE0001};
    vecs[2] = '{1, 16'hFFFF, 16'hFFFF, 2'b11, 32'h00000001};
    vecs[3] = '{3, 16'hFFFF, 16'h0002, 2'b10, 32'hFFFFFFFE};
    vecs[4] = '{1, 16'h7FFF, 16'h8000, 2'b01, 32'hC0008000};
    vecs[5] = '{0, 16'h1234, 16'h0010, 2'b00, 32'h00012340};
    rr_exp  = '{0, 1, 2, 3, 0};

    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_sign_mode = '0;
    rst_n = 1'b0;
    tick();
    do_reset();

    for (int v = 0; v < 6; v++)
      do_txn(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sm, vecs[v].exp, 1'b0, lat, 0);

    // Result held while the owner stalls; other ready bits must be ignored.
    do_txn(2, 16'h0003, 16'h0007, 2'b00, 32'h00000015, 1'b0, lat, 5);

    // Multiplier never answers: abort after TIMEOUT wait cycles.
    model_en = 1'b0;
    do_txn(1, 16'h00FF, 16'h00FF, 2'b00, 32'h00000000, 1'b1, TIMEOUT, 0);
    model_en = 1'b1;

    // All requesters pending from reset: strict rotation.
    lat = 2;
    rst_n = 1'b0;
    req_valid = '1;
    rsp_ready = '1;
    tick();
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      bit got;
      int gid;
      got = 0; gid = -1;
      for (int k = 0; k < 100; k++) begin
        if (req_ready != '0) begin got = 1; break; end
        tick();
      end
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
      chk("rr_grant_seen", 64'(got), 64'd1);
      chk("rr_onehot", 64'($onehot(req_ready)), 64'd1);
      chk("rr_order", 64'(gid), 64'(rr_exp[g]));
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 10; k++) tick();
    rsp_ready = '0;
    lat = 6;
    do_reset();

    // Reset while WAIT is in flight, then a stray mul_done.
    req_a[WIDTH +: WIDTH] = 16'h0AAA;
    req_b[WIDTH +: WIDTH] = 16'h0055;
    req_sign_mode[3:2] = 2'b11;
    req_valid = 4'b0010;
    #1;
    tick();
    req_valid = '0;
    chk("midwait_started", 64'(mul_start), 64'd1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check_all_zero("midwait_rst");
    tick();
    rst_n = 1'b1;
    tick();
    stray = 1'b1;
    tick();
    stray = 1'b0;
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
        if (rsp_valid != '0) seen = 1;
        tick();
      end
      chk("stray_no_rsp", 64'(seen), 64'd0);
    end
    check_all_zero("after_stray");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
